irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 21 ++
 rtl/irq_ctrl.sv | 133 +++++++++++++
 tb/tb_irq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count, register map
// and controller state encoding.
package irq_ctrl_pkg;

  localparam int unsigned NSRC = 6;
  localparam int unsigned VecW = 3;

  // Register select values seen on addr[3:2]
  localparam logic [1:0] RegCtrl  = 2'd0;
  localparam logic [1:0] RegMask  = 2'd1;
  localparam logic [1:0] RegPend  = 2'd2;
  localparam logic [1:0] RegCause = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; bit 0 is the highest priority.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [VecW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VecW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask/enable registers and a
// request/service handshake with the CPU that acknowledges the serviced device.
module irq_ctrl #(
  parameter int unsigned NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic            intcwr,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  input  logic [NSRC-1:0] dev_irq,
  output logic [NSRC-1:0] dev_clr,
  input  logic            cpu_ack,
  input  logic            cpu_eret,
  output logic            cpu_irq,
  output logic [2:0]      irq_vec
);
  import irq_ctrl_pkg::*;

  state_e          state_q, state_d;
  logic            ie_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] prev_q;
  logic            armed_q;
  logic [2:0]      vec_q, vec_d;
  logic            cpu_irq_q;
  logic [NSRC-1:0] dev_clr_q, dev_clr_d;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] rise;
  logic            wr_ctrl, wr_mask;
  logic            win_valid;
  logic [2:0]      win_idx;
  logic            unused_bus;

  assign unused_bus = ^{addr[31:4], addr[1:0], din[31:NSRC]};

  irq_prio_enc u_prio_enc (
    .req   (pend_q & mask_q),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign wr_ctrl = intcwr && (addr[3:2] == RegCtrl);
  assign wr_mask = intcwr && (addr[3:2] == RegMask);
  assign w1c     = (intcwr && (addr[3:2] == RegPend)) ? din[NSRC-1:0] : '0;

  // The first clock after reset only loads prev_q, so levels already high are
  // not mistaken for edges.
  assign rise    = dev_irq & ~prev_q & {NSRC{armed_q}};

  // New edges win over both software and acknowledge clears.
  assign pend_d  = (pend_q & ~(w1c | ack_clr)) | rise;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    dev_clr_d = '0;
    ack_clr   = '0;
    unique case (state_q)
      StIdle: begin
        if (ie_q && win_valid) begin
          state_d = StReq;
          vec_d   = win_idx;
        end
      end
      StReq: begin
        if (!ie_q || !mask_q[vec_q]) begin
          state_d = StIdle;
        end else if (cpu_ack) begin
          state_d          = StService;
          ack_clr[vec_q]   = 1'b1;
          dev_clr_d[vec_q] = 1'b1;
        end
      end
      StService: begin
        if (cpu_eret) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ie_q      <= 1'b0;
      mask_q    <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      armed_q   <= 1'b0;
      vec_q     <= '0;
      cpu_irq_q <= 1'b0;
      dev_clr_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      prev_q    <= dev_irq;
      armed_q   <= 1'b1;
      vec_q     <= vec_d;
      cpu_irq_q <= (state_d == StReq);
      dev_clr_q <= dev_clr_d;
      if (wr_ctrl) begin
        ie_q <= din[0];
      end
      if (wr_mask) begin
        mask_q <= din[NSRC-1:0];
      end
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr[3:2])
      RegCtrl:  dout[0]         = ie_q;
      RegMask:  dout[NSRC-1:0]  = mask_q;
      RegPend:  dout[NSRC-1:0]  = pend_q;
      RegCause: begin
        dout[25:24] = state_q;
        dout[2:0]   = vec_q;
      end
      default: dout = '0;
    endcase
  end

  assign cpu_irq = cpu_irq_q;
  assign irq_vec = vec_q;
  assign dev_clr = dev_clr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a cycle-level behavioural model checked against
// the DUT on every falling edge, plus literal expectations at key points.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        intcwr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  dev_irq;
  logic [5:0]  dev_clr;
  logic        cpu_ack;
  logic        cpu_eret;
  logic        cpu_irq;
  logic [2:0]  irq_vec;

  int n_pass  = 0;
  int n_total = 0;
  bit done    = 1'b0;

  // Model state: 0 idle, 1 requesting, 2 in handler
  int         m_state = 0;
  logic       m_ie    = 1'b0;
  logic [5:0] m_mask  = '0;
  logic [5:0] m_pend  = '0;
  logic [5:0] m_prev  = '0;
  logic       m_armed = 1'b0;
  int         m_vec   = 0;
  logic       m_irq   = 1'b0;
  logic [5:0] m_clr   = '0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .intcwr   (intcwr),
    .din      (din),
    .dout     (dout),
    .dev_irq  (dev_irq),
    .dev_clr  (dev_clr),
    .cpu_ack  (cpu_ack),
    .cpu_eret (cpu_eret),
    .cpu_irq  (cpu_irq),
    .irq_vec  (irq_vec)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {31'd0, m_ie};
      2'd1:    return {26'd0, m_mask};
      2'd2:    return {26'd0, m_pend};
      default: return (m_state << 24) | m_vec;
    endcase
  endfunction

  task automatic model_step();
    logic [5:0] rises;
    logic [5:0] cleared;
    if (reset) begin
      m_state = 0; m_ie = 0; m_mask = 0; m_pend = 0; m_prev = 0;
      m_armed = 0; m_vec = 0; m_irq = 0; m_clr = 0;
    end else begin
      rises   = m_armed ? (dev_irq & ~m_prev) : 6'd0;
      m_prev  = dev_irq;
      m_armed = 1'b1;
      cleared = 6'd0;
      m_clr   = 6'd0;
      if (m_state == 0) begin
        if (m_ie && (m_pend & m_mask) != 6'd0) begin
          m_vec   = lowest(m_pend & m_mask);
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (!m_ie || !m_mask[m_vec]) m_state = 0;
        else if (cpu_ack) begin
          cleared[m_vec] = 1'b1;
          m_clr[m_vec]   = 1'b1;
          m_state        = 2;
        end
      end else if (cpu_eret) begin
        m_state = 0;
      end
      if (intcwr) begin
        case (addr[3:2])
          2'd0: m_ie = din[0];
          2'd1: m_mask = din[5:0];
          2'd2: cleared = cleared | din[5:0];
          default: ;
        endcase
      end
      m_pend = (m_pend & ~cleared) | rises;
      m_irq  = (m_state == 1);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!done) begin
      check("cyc_cpu_irq", {31'd0, cpu_irq}, {31'd0, m_irq});
      check("cyc_irq_vec", {29'd0, irq_vec}, m_vec);
      check("cyc_dev_clr", {26'd0, dev_clr}, {26'd0, m_clr});
      check("cyc_dout", dout, model_read(addr[3:2]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    intcwr   = 1'b0;
    cpu_ack  = 1'b0;
    cpu_eret = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    din    = d;
    intcwr = 1'b1;
    cyc();
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  initial begin
    reset = 1'b1; addr = '0; din = '0; intcwr = 1'b0;
    cpu_ack = 1'b0; cpu_eret = 1'b0; dev_irq = 6'b010000;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_mask", 32'h4, 32'h0);
    rd_chk("rst_pend", 32'h8, 32'h0);
    check("rst_cpu_irq", {31'd0, cpu_irq}, 32'h0);
    check("rst_dev_clr", {26'd0, dev_clr}, 32'h0);
    cyc(); cyc();
    rd_chk("level_at_release_no_edge", 32'h8, 32'h0);
    dev_irq = 6'b000000;
    cyc();

    // Single source, bit 0
    wr(32'h0, 32'h1);
    wr(32'h4, 32'h1);
    dev_irq = 6'b000001;
    cyc();
    rd_chk("pend_after_1clk", 32'h8, 32'h1);
    check("no_irq_after_1clk", {31'd0, cpu_irq}, 32'h0);
    cyc();
    check("irq_after_2clk", {31'd0, cpu_irq}, 32'h1);
    check("vec0", {29'd0, irq_vec}, 32'h0);
    cpu_ack = 1'b1;
    cyc();
    check("ack_dev_clr", {26'd0, dev_clr}, 32'h01);
    check("ack_drops_irq", {31'd0, cpu_irq}, 32'h0);
    rd_chk("ack_pend_clr", 32'h8, 32'h0);
    rd_chk("ack_cause_service", 32'hC, 32'h0200_0000);
    cyc();
    check("dev_clr_one_cycle", {26'd0, dev_clr}, 32'h0);
    cpu_eret = 1'b1;
    cyc();
    dev_irq = 6'b000000;
    cpu_ack = 1'b1;
    cyc();
    check("ack_in_idle_ignored", {26'd0, dev_clr}, 32'h0);

    // Two simultaneous sources: 1 wins, 3 follows after eret
    wr(32'h4, 32'h3F);
    dev_irq = 6'b001010;
    cyc();
    rd_chk("pend_two", 32'h8, 32'h0A);
    cyc();
    check("two_irq", {31'd0, cpu_irq}, 32'h1);
    check("two_vec1", {29'd0, irq_vec}, 32'h1);
    cpu_eret = 1'b1;
    cyc();
    check("eret_in_req_ignored", {31'd0, cpu_irq}, 32'h1);
    cpu_ack = 1'b1;
    cyc();
    check("two_clr1", {26'd0, dev_clr}, 32'h02);
    rd_chk("two_pend_left", 32'h8, 32'h08);
    cpu_eret = 1'b1;
    cyc();
    check("after_eret_idle", {31'd0, cpu_irq}, 32'h0);
    cyc();
    check("second_irq", {31'd0, cpu_irq}, 32'h1);
    check("second_vec3", {29'd0, irq_vec}, 32'h3);
    cpu_ack = 1'b1;
    cyc();
    cpu_eret = 1'b1;
    cyc();
    dev_irq = 6'b000000;
    cyc();

    // Mask withdrawal while requesting
    dev_irq = 6'b000100;
    cyc(); cyc();
    check("wd_irq", {31'd0, cpu_irq}, 32'h1);
    check("wd_vec2", {29'd0, irq_vec}, 32'h2);
    wr(32'h4, 32'h0);
    cyc();
    check("wd_irq_dropped", {31'd0, cpu_irq}, 32'h0);
    check("wd_no_clr", {26'd0, dev_clr}, 32'h0);
    rd_chk("wd_pend_kept", 32'h8, 32'h04);
    rd_chk("wd_cause_idle", 32'hC, 32'h0000_0002);
    wr(32'h8, 32'h4);
    rd_chk("w1c_clears", 32'h8, 32'h0);
    dev_irq = 6'b000000;
    cyc();

    // W1C colliding with a new edge on the same bit
    dev_irq = 6'b000100;
    wr(32'h8, 32'h4);
    rd_chk("set_beats_w1c", 32'h8, 32'h04);
    wr(32'h8, 32'hFFFF_FFC4);
    rd_chk("w1c_after", 32'h8, 32'h0);
    dev_irq = 6'b000000;
    cyc();

    // Reset in the middle of servicing
    wr(32'h4, 32'h9);
    dev_irq = 6'b000001;
    cyc(); cyc();
    check("svc_irq", {31'd0, cpu_irq}, 32'h1);
    cpu_ack = 1'b1;
    dev_irq = 6'b001001;
    cyc();
    check("svc_clr", {26'd0, dev_clr}, 32'h01);
    check("svc_no_nesting", {31'd0, cpu_irq}, 32'h0);
    rd_chk("svc_pend_edge", 32'h8, 32'h08);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cpu_irq", {31'd0, cpu_irq}, 32'h0);
    check("mid_rst_dev_clr", {26'd0, dev_clr}, 32'h0);
    rd_chk("mid_rst_pend", 32'h8, 32'h0);
    rd_chk("mid_rst_mask", 32'h4, 32'h0);
    rd_chk("mid_rst_cause", 32'hC, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("post_rst_dev_clr", {26'd0, dev_clr}, 32'h0);
    check("post_rst_cpu_irq", {31'd0, cpu_irq}, 32'h0);
    rd_chk("post_rst_pend", 32'h8, 32'h0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
